// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - shared zigzag table, block constants and stats type for the CAVLC scan buffer
package cavlc_pkg;

  localparam int BLK_COEFFS = 16;

  // Zigzag position -> raster index (r*4+c) for a 4x4 block
  localparam logic [3:0] ZZ_TO_RASTER [BLK_COEFFS] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  typedef struct packed {
    logic [4:0] total_coeff;
    logic [1:0] trailing_ones;
  } blk_stats_t;

  function automatic logic [3:0] zz2raster(input logic [3:0] pos);
    return ZZ_TO_RASTER[pos];
  endfunction

endpackage

// File: rtl/cavlc_block_stats.sv
// rtl/cavlc_block_stats.sv - combinational total_coeff / trailing_ones of one 4x4 block
// Ports:
//   block : 16 raster coefficients, element r*4+c at [(r*4+c)*COEFF_W +: COEFF_W]
//   stats : total_coeff (nonzero count, 0..16) and trailing_ones (0..3)
module cavlc_block_stats
  import cavlc_pkg::*;
#(
  parameter int COEFF_W = 8
) (
  input  logic [BLK_COEFFS*COEFF_W-1:0] block,
  output blk_stats_t                    stats
);

  localparam logic signed [COEFF_W-1:0] PLUS_ONE  = COEFF_W'(1);
  localparam logic signed [COEFF_W-1:0] MINUS_ONE = '1;

  logic [4:0]                nz;
  logic [1:0]                t1;
  logic                      stop;
  logic signed [COEFF_W-1:0] v;

  // Walk from the highest zigzag position down; zeros are skipped for the
  // trailing-ones run, which ends at the first magnitude above one.
  always_comb begin
    nz   = '0;
    t1   = '0;
    stop = 1'b0;
    v    = '0;
    for (int p = BLK_COEFFS - 1; p >= 0; p--) begin
      v = block[int'(zz2raster(4'(p)))*COEFF_W +: COEFF_W];
      if (v != '0) begin
        nz = nz + 5'd1;
        if (!stop) begin
          if (v == PLUS_ONE || v == MINUS_ONE) begin
            if (t1 != 2'd3) t1 = t1 + 2'd1;
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
    stats.total_coeff   = nz;
    stats.trailing_ones = t1;
  end

endmodule

// File: rtl/cavlc_coeff_scan_buffer.sv
// rtl/cavlc_coeff_scan_buffer.sv - multi-bank 4x4 block store streaming coefficients in zigzag order
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : whole-block load handshake; in_ready while a bank is free
//   in_block          : 16 raster coefficients; in_scan_rev selects high-to-low zigzag
//   out_valid/out_ready : per-coefficient handshake towards the CAVLC core
//   out_coeff, out_idx  : coefficient and its zigzag position
//   out_first, out_last : first / final beat of a block
//   occupancy           : number of full banks
// Optional (macro CAVLC_SCAN_STATS_EN): out_total_coeff, out_trailing_ones per block.
module cavlc_coeff_scan_buffer
  import cavlc_pkg::*;
#(
  parameter int COEFF_W = 8,
  parameter int BANKS   = 2,
  parameter int CNT_W   = $clog2(BANKS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BLK_COEFFS*COEFF_W-1:0] in_block,
  input  logic                          in_scan_rev,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [COEFF_W-1:0]     out_coeff,
  output logic [3:0]                    out_idx,
  output logic                          out_first,
  output logic                          out_last,
  output logic [CNT_W-1:0]              occupancy
`ifdef CAVLC_SCAN_STATS_EN
  ,
  output logic [4:0]                    out_total_coeff,
  output logic [1:0]                    out_trailing_ones
`endif
);

  localparam int PTR_W = $clog2(BANKS);

  logic [BLK_COEFFS*COEFF_W-1:0] bank [BANKS];
  logic [BANKS-1:0]              rev;
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              count;
  logic [3:0]                    beat;
  logic [3:0]                    pos;
  logic [3:0]                    raster;
  logic                          load;
  logic                          beat_fire;
  logic                          pop_last;

  // Ready depends only on registered count, so there is no path from
  // out_ready to in_ready.
  assign in_ready  = (count != CNT_W'(BANKS));
  assign out_valid = (count != '0);
  assign occupancy = count;

  assign load      = in_valid && in_ready;
  assign beat_fire = out_valid && out_ready;
  assign pop_last  = beat_fire && (beat == 4'd15);

  assign pos    = rev[rd_ptr] ? (4'd15 - beat) : beat;
  assign raster = zz2raster(pos);

  always_comb begin
    out_coeff = '0;
    out_idx   = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_coeff = bank[rd_ptr][int'(raster)*COEFF_W +: COEFF_W];
      out_idx   = pos;
      out_first = (beat == 4'd0);
      out_last  = (beat == 4'd15);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= '0;
    end else begin
      if (load) wr_ptr <= wr_ptr + PTR_W'(1);
      if (beat_fire) beat <= pop_last ? 4'd0 : beat + 4'd1;
      if (pop_last) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({load, pop_last})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bank payload is not reset; it is only meaningful while counted as full.
  always_ff @(posedge clk) begin
    if (load && !rst) begin
      bank[wr_ptr] <= in_block;
      rev[wr_ptr]  <= in_scan_rev;
    end
  end

`ifdef CAVLC_SCAN_STATS_EN
  blk_stats_t load_stats;
  blk_stats_t stats_mem [BANKS];

  cavlc_block_stats #(
    .COEFF_W (COEFF_W)
  ) u_stats (
    .block (in_block),
    .stats (load_stats)
  );

  always_ff @(posedge clk) begin
    if (load && !rst) stats_mem[wr_ptr] <= load_stats;
  end

  assign out_total_coeff   = out_valid ? stats_mem[rd_ptr].total_coeff   : 5'd0;
  assign out_trailing_ones = out_valid ? stats_mem[rd_ptr].trailing_ones : 2'd0;
`endif

endmodule

// File: tb/tb_cavlc_coeff_scan_buffer.sv
// tb/tb_cavlc_coeff_scan_buffer.sv - scoreboard bench for cavlc_coeff_scan_buffer
module tb_cavlc_coeff_scan_buffer;

  localparam int CW   = 8;
  localparam int NB   = 2;
  localparam int CNTW = $clog2(NB + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [16*CW-1:0] in_block = '0;
  logic            in_scan_rev = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_coeff;
  logic [3:0]      out_idx;
  logic            out_first;
  logic            out_last;
  logic [CNTW-1:0] occupancy;
`ifdef CAVLC_SCAN_STATS_EN
  logic [4:0]      out_total_coeff;
  logic [1:0]      out_trailing_ones;
`endif

  cavlc_coeff_scan_buffer #(
    .COEFF_W (CW),
    .BANKS   (NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_block    (in_block),
    .in_scan_rev (in_scan_rev),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_coeff   (out_coeff),
    .out_idx     (out_idx),
    .out_first   (out_first),
    .out_last    (out_last),
    .occupancy   (occupancy)
`ifdef CAVLC_SCAN_STATS_EN
    ,
    .out_total_coeff   (out_total_coeff),
    .out_trailing_ones (out_trailing_ones)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] coeff;
    logic [3:0]    idx;
    logic          first;
    logic          last;
    logic [4:0]    tc;
    logic [1:0]    t1;
  } beat_t;

  beat_t q[$];
  int tests = 0;
  int fails = 0;
  int load_count = 0;
  bit load_pend = 1'b0;
  logic [16*CW-1:0] pend_blk;
  logic pend_rev;
  int ready_mode = 1;
  int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted block becomes 16 expected beats in scan order.
  function automatic void push_block(input logic [16*CW-1:0] blk, input logic rv);
    logic signed [CW-1:0] vals [16];
    int tc = 0;
    int t1 = 0;
    bit stop = 1'b0;
    beat_t e;
    for (int p = 0; p < 16; p++) vals[p] = blk[zz[p]*CW +: CW];
    for (int p = 15; p >= 0; p--) begin
      int v = vals[p];
      int a = (v < 0) ? -v : v;
      if (a != 0) tc++;
      if (a != 0 && !stop) begin
        if (a == 1) t1 = (t1 < 3) ? t1 + 1 : 3;
        else stop = 1'b1;
      end
    end
    for (int b = 0; b < 16; b++) begin
      int p = rv ? 15 - b : b;
      e.coeff = vals[p];
      e.idx   = 4'(p);
      e.first = (b == 0);
      e.last  = (b == 15);
      e.tc    = 5'(tc);
      e.t1    = 2'(t1);
      q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin : monitor
    int nb;
    beat_t e;
    if (rst) begin
      q.delete();
      load_pend = 1'b0;
    end else begin
      nb = (q.size() + 15) / 16;
      check("occupancy", 32'(occupancy), 32'(nb));
      check("in_ready", 32'(in_ready), 32'(nb < NB));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        e = q[0];
        check("out_coeff", 32'(out_coeff), 32'(e.coeff));
        check("out_idx", 32'(out_idx), 32'(e.idx));
        check("out_first", 32'(out_first), 32'(e.first));
        check("out_last", 32'(out_last), 32'(e.last));
`ifdef CAVLC_SCAN_STATS_EN
        check("total_coeff", 32'(out_total_coeff), 32'(e.tc));
        check("trailing_ones", 32'(out_trailing_ones), 32'(e.t1));
`endif
        if (out_ready) void'(q.pop_front());
      end else begin
        check("idle_outputs", {out_coeff, out_idx, out_first, out_last}, '0);
`ifdef CAVLC_SCAN_STATS_EN
        check("idle_stats", {out_total_coeff, out_trailing_ones}, '0);
`endif
      end
      load_pend = in_valid && (nb < NB);
      pend_blk  = in_block;
      pend_rev  = in_scan_rev;
    end
  end

  always @(posedge clk) begin
    if (load_pend) begin
      push_block(pend_blk, pend_rev);
      load_count++;
      load_pend = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic do_load(input logic [16*CW-1:0] blk, input logic rv, input int budget, output bit ok);
    int start = load_count;
    in_block    = blk;
    in_scan_rev = rv;
    in_valid    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (load_count != start) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q.size() == n) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("wait_queue", 32'(found), 32'd1);
  endtask

  function automatic logic [16*CW-1:0] rand_block();
    logic [16*CW-1:0] b;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       b[i*CW +: CW] = '0;
        1:       b[i*CW +: CW] = ($urandom_range(0, 1) != 0) ? CW'(1) : '1;
        2:       b[i*CW +: CW] = CW'($urandom_range(0, 6) - 3);
        default: b[i*CW +: CW] = CW'($urandom);
      endcase
    end
    return b;
  endfunction

  initial begin : stim
    logic [16*CW-1:0] ramp;
    logic [16*CW-1:0] blk;
    logic signed [CW-1:0] sv [16];
    bit ok;

    for (int i = 0; i < 16; i++) ramp[i*CW +: CW] = CW'(i);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);

    ready_mode = 1;
    do_load(ramp, 1'b1, 20, ok);
    check("load_rev", 32'(ok), 32'd1);
    wait_q(0, 100);
    do_load(ramp, 1'b0, 20, ok);
    check("load_fwd", 32'(ok), 32'd1);
    wait_q(0, 100);

    ready_mode = 0;
    do_load(rand_block(), 1'b0, 20, ok);
    check("full_load_a", 32'(ok), 32'd1);
    do_load(rand_block(), 1'b1, 20, ok);
    check("full_load_b", 32'(ok), 32'd1);
    check("full_occupancy", 32'(occupancy), NB);
    check("full_in_ready", 32'(in_ready), 32'd0);
    blk = rand_block();
    do_load(blk, 1'b0, 5, ok);
    check("full_reject", 32'(ok), 32'd0);
    ready_mode = 1;
    do_load(blk, 1'b0, 40, ok);
    check("full_after_drain", 32'(ok), 32'd1);
    wait_q(0, 200);

    do_load(rand_block(), 1'b1, 20, ok);
    check("stall_load", 32'(ok), 32'd1);
    wait_q(11, 50);
    ready_mode = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    wait_q(0, 100);

    do_load(rand_block(), 1'b0, 20, ok);
    check("simul_load_a", 32'(ok), 32'd1);
    wait_q(1, 50);
    do_load(rand_block(), 1'b1, 3, ok);
    check("simul_load_b", 32'(ok), 32'd1);
    check("simul_occupancy", 32'(occupancy), 32'd1);
    check("simul_first", 32'(out_first), 32'd1);
    wait_q(0, 100);

    for (int p = 0; p < 16; p++) sv[p] = '0;
    sv[15] = -1; sv[13] = 1; sv[12] = 1; sv[11] = -1; sv[0] = 5;
    for (int p = 0; p < 16; p++) blk[zz[p]*CW +: CW] = sv[p];
    do_load(blk, 1'b1, 20, ok);
    check("stats_load", 32'(ok), 32'd1);
`ifdef CAVLC_SCAN_STATS_EN
    check("stats_total", 32'(out_total_coeff), 32'd5);
    check("stats_t1", 32'(out_trailing_ones), 32'd3);
`endif
    wait_q(0, 100);

    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      do_load(rand_block(), 1'($urandom_range(0, 1)), 300, ok);
      check("rand_load", 32'(ok), 32'd1);
    end
    ready_mode = 1;
    wait_q(0, 200);

    ready_mode = 0;
    do_load(rand_block(), 1'b1, 20, ok);
    do_load(rand_block(), 1'b0, 20, ok);
    ready_mode = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_occupancy", 32'(occupancy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_outputs", {out_coeff, out_idx, out_first, out_last}, '0);
    do_load(ramp, 1'b0, 20, ok);
    check("post_rst_load", 32'(ok), 32'd1);
    wait_q(0, 100);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
